// File: rtl/id_pkg.sv
// Shared decode constants for the instruction-decode stage: opcodes, ALU
// operation codes, control-bundle bit offsets and stack-operation encodings.
package id_pkg;

   localparam int CTRL_W = 17;

   // Opcodes (Instr[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_JR    = 6'b000101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_PUSH  = 6'b110000;
   localparam logic [5:0] OP_POP   = 6'b110001;

   // ALU operation codes
   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0011;
   localparam logic [3:0] ALU_PUSH = 4'b1100;

   // Bit offsets inside the packed control bundle (MSB first)
   localparam int CB_REGDST   = 16;
   localparam int CB_REGWRITE = 15;
   localparam int CB_MEMREAD  = 14;
   localparam int CB_MEMWRITE = 13;
   localparam int CB_MEMTOREG = 12;
   localparam int CB_NEEDZEXT = 11;
   localparam int CB_ALUSRC   = 10;
   localparam int CB_ALUOP_LO = 6;   // ALUop occupies [9:6]
   localparam int CB_BRANCH   = 5;
   localparam int CB_JUMP_LO  = 3;   // Jump occupies [4:3]
   localparam int CB_LINK     = 2;
   localparam int CB_STACK_LO = 0;   // StackOp occupies [1:0]

   localparam logic [1:0] JUMP_ABS = 2'b01;
   localparam logic [1:0] JUMP_REG = 2'b10;

   typedef enum logic [1:0] {
      STACKOP_NONE = 2'b00,
      STACKOP_PUSH = 2'b10,
      STACKOP_POP  = 2'b11
   } stackop_e;

endpackage

// File: rtl/id_decode.sv
// Combinational opcode/funct decoder producing the control bundle, the
// resolved destination register, the rt-is-read flag and the illegal flag.
module id_decode
   import id_pkg::*;
#(
   parameter int LINK_REG = 31
) (
   input  logic [5:0]        opcode_i,
   input  logic [3:0]        funct_i,
   input  logic [4:0]        rt_i,
   input  logic [4:0]        rd_i,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic [4:0]        dst_o,
   output logic              rt_read_o,
   output logic              illegal_o
);

   // Opcode lookup; every field not listed for an opcode stays zero
   always_comb begin
      ctrl_o    = '0;
      rt_read_o = 1'b0;
      illegal_o = 1'b0;
      case (opcode_i)
         OP_RTYPE: begin
            ctrl_o[CB_REGDST]          = 1'b1;
            ctrl_o[CB_REGWRITE]        = 1'b1;
            ctrl_o[CB_ALUOP_LO +: 4]   = funct_i;
            rt_read_o                  = 1'b1;
         end
         OP_ADDI: begin
            ctrl_o[CB_REGWRITE]        = 1'b1;
            ctrl_o[CB_ALUSRC]          = 1'b1;
            ctrl_o[CB_ALUOP_LO +: 4]   = ALU_ADD;
         end
         OP_ANDI: begin
            ctrl_o[CB_REGWRITE]        = 1'b1;
            ctrl_o[CB_NEEDZEXT]        = 1'b1;
            ctrl_o[CB_ALUSRC]          = 1'b1;
            ctrl_o[CB_ALUOP_LO +: 4]   = ALU_AND;
         end
         OP_ORI: begin
            ctrl_o[CB_REGWRITE]        = 1'b1;
            ctrl_o[CB_NEEDZEXT]        = 1'b1;
            ctrl_o[CB_ALUSRC]          = 1'b1;
            ctrl_o[CB_ALUOP_LO +: 4]   = ALU_OR;
         end
         OP_BEQ: begin
            ctrl_o[CB_BRANCH]          = 1'b1;
            ctrl_o[CB_ALUOP_LO +: 4]   = ALU_SUB;
            rt_read_o                  = 1'b1;
         end
         OP_J: begin
            ctrl_o[CB_JUMP_LO +: 2]    = JUMP_ABS;
         end
         OP_JAL: begin
            ctrl_o[CB_JUMP_LO +: 2]    = JUMP_ABS;
            ctrl_o[CB_LINK]            = 1'b1;
            ctrl_o[CB_REGWRITE]        = 1'b1;
         end
         OP_JR: begin
            ctrl_o[CB_JUMP_LO +: 2]    = JUMP_REG;
         end
         OP_LW: begin
            ctrl_o[CB_REGWRITE]        = 1'b1;
            ctrl_o[CB_MEMREAD]         = 1'b1;
            ctrl_o[CB_MEMTOREG]        = 1'b1;
            ctrl_o[CB_ALUSRC]          = 1'b1;
            ctrl_o[CB_ALUOP_LO +: 4]   = ALU_ADD;
         end
         OP_SW: begin
            ctrl_o[CB_MEMWRITE]        = 1'b1;
            ctrl_o[CB_ALUSRC]          = 1'b1;
            ctrl_o[CB_ALUOP_LO +: 4]   = ALU_ADD;
            rt_read_o                  = 1'b1;
         end
         OP_PUSH: begin
            ctrl_o[CB_ALUSRC]          = 1'b1;
            ctrl_o[CB_ALUOP_LO +: 4]   = ALU_PUSH;
            ctrl_o[CB_STACK_LO +: 2]   = STACKOP_PUSH;
            rt_read_o                  = 1'b1;
         end
         OP_POP: begin
            ctrl_o[CB_REGDST]          = 1'b1;
            ctrl_o[CB_REGWRITE]        = 1'b1;
            ctrl_o[CB_MEMTOREG]        = 1'b1;
            ctrl_o[CB_MEMREAD]         = 1'b1;
            ctrl_o[CB_STACK_LO +: 2]   = STACKOP_POP;
         end
         default: begin
            illegal_o = 1'b1;
         end
      endcase
   end

   // Destination select: rd for register-format writes, link register for jal
   always_comb begin
      if (ctrl_o[CB_REGDST])    dst_o = rd_i;
      else if (ctrl_o[CB_LINK]) dst_o = 5'(LINK_REG);
      else                      dst_o = rt_i;
   end

endmodule

// File: rtl/id_stage.sv
// Registered instruction-decode stage: decodes the fetched word into the ID/EX
// register under a valid/ready handshake, stalls on load-use hazards, supports
// flush, and tracks a hardware stack pointer for push/pop.
module id_stage
   import id_pkg::*;
#(
   parameter  int ADDR_W      = 32,
   parameter  int STACK_DEPTH = 16,
   parameter  int LINK_REG    = 31,
   localparam int SP_W        = $clog2(STACK_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              InValid,
   output logic              InReady,
   input  logic [31:0]       Instr,
   input  logic [ADDR_W-1:0] InPC,
   input  logic              Flush,
   output logic              OutValid,
   input  logic              OutReady,
   output logic [CTRL_W-1:0] Ctrl,
   output logic [4:0]        Rs,
   output logic [4:0]        Rt,
   output logic [4:0]        Dst,
   output logic [15:0]       Imm16,
   output logic [ADDR_W-1:0] OutPC,
   output logic [SP_W-1:0]   StackAddr,
   output logic              IllegalOp,
   output logic              StackFault
);

   localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

   logic [CTRL_W-1:0] dec_ctrl;
   logic [4:0]        dec_dst;
   logic              dec_rt_read;
   logic              dec_illegal;

   logic              valid_q, valid_d;
   logic [CTRL_W-1:0] ctrl_q;
   logic [4:0]        rs_q, rt_q, dst_q;
   logic [15:0]       imm_q;
   logic [ADDR_W-1:0] pc_q;
   logic [SP_W-1:0]   saddr_q, saddr_d;
   logic              illegal_q;
   logic              entry_fault_q, entry_fault_d;
   logic              sfault_q, sfault_d;
   logic [SP_W-1:0]   sp_q, sp_d;
   logic              hazard, accept;

   id_decode #(.LINK_REG(LINK_REG)) u_decode (
      .opcode_i  (Instr[31:26]),
      .funct_i   (Instr[3:0]),
      .rt_i      (Instr[20:16]),
      .rd_i      (Instr[15:11]),
      .ctrl_o    (dec_ctrl),
      .dst_o     (dec_dst),
      .rt_read_o (dec_rt_read),
      .illegal_o (dec_illegal)
   );

   // Load-use hazard and input handshake; Flush blocks acceptance outright
   always_comb begin
      hazard  = valid_q & ctrl_q[CB_MEMREAD] & (dst_q != 5'd0) & InValid &
                ((Instr[25:21] == dst_q) | (dec_rt_read & (Instr[20:16] == dst_q)));
      InReady = ~rst & ~Flush & ~hazard & (~valid_q | OutReady);
      accept  = InValid & InReady;
   end

   // Output-valid next state: flush beats accept, consume without refill drains
   always_comb begin
      if (Flush)         valid_d = 1'b0;
      else if (accept)   valid_d = 1'b1;
      else if (OutReady) valid_d = 1'b0;
      else               valid_d = valid_q;
   end

   // Stack pointer: allocate on accepted push/pop, undo when the entry is flushed
   always_comb begin
      sp_d          = sp_q;
      saddr_d       = '0;
      entry_fault_d = 1'b0;
      sfault_d      = sfault_q;
      if (Flush) begin
         if (valid_q && !entry_fault_q && ctrl_q[CB_STACK_LO +: 2] == STACKOP_PUSH)
            sp_d = sp_q - 1'b1;
         else if (valid_q && !entry_fault_q && ctrl_q[CB_STACK_LO +: 2] == STACKOP_POP)
            sp_d = sp_q + 1'b1;
      end else if (accept) begin
         if (dec_ctrl[CB_STACK_LO +: 2] == STACKOP_PUSH) begin
            if (sp_q != SP_FULL) begin
               saddr_d = sp_q;
               sp_d    = sp_q + 1'b1;
            end else begin
               entry_fault_d = 1'b1;
               sfault_d      = 1'b1;
            end
         end else if (dec_ctrl[CB_STACK_LO +: 2] == STACKOP_POP) begin
            if (sp_q != '0) begin
               saddr_d = sp_q - 1'b1;
               sp_d    = sp_q - 1'b1;
            end else begin
               entry_fault_d = 1'b1;
               sfault_d      = 1'b1;
            end
         end
      end
   end

   // ID/EX register: payload loads only on accept so it holds while stalled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q       <= 1'b0;
         ctrl_q        <= '0;
         rs_q          <= '0;
         rt_q          <= '0;
         dst_q         <= '0;
         imm_q         <= '0;
         pc_q          <= '0;
         saddr_q       <= '0;
         illegal_q     <= 1'b0;
         entry_fault_q <= 1'b0;
         sfault_q      <= 1'b0;
         sp_q          <= '0;
      end else begin
         valid_q  <= valid_d;
         sp_q     <= sp_d;
         sfault_q <= sfault_d;
         if (accept) begin
            ctrl_q        <= dec_ctrl;
            rs_q          <= Instr[25:21];
            rt_q          <= Instr[20:16];
            dst_q         <= dec_dst;
            imm_q         <= Instr[15:0];
            pc_q          <= InPC;
            saddr_q       <= saddr_d;
            illegal_q     <= dec_illegal;
            entry_fault_q <= entry_fault_d;
         end
      end
   end

   assign OutValid   = valid_q;
   assign Ctrl       = ctrl_q;
   assign Rs         = rs_q;
   assign Rt         = rt_q;
   assign Dst        = dst_q;
   assign Imm16      = imm_q;
   assign OutPC      = pc_q;
   assign StackAddr  = saddr_q;
   assign IllegalOp  = illegal_q;
   assign StackFault = sfault_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage with a 4-entry stack: decode, load-use stall,
// stack bounds, flush undo, illegal opcode hold and asynchronous reset.
module tb_id_stage;

   localparam int ADDR_W = 32;
   localparam int DEPTH  = 4;
   localparam int SP_W   = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic              InValid, InReady, Flush, OutValid, OutReady;
   logic [31:0]       Instr;
   logic [ADDR_W-1:0] InPC, OutPC;
   logic [16:0]       Ctrl;
   logic [4:0]        Rs, Rt, Dst;
   logic [15:0]       Imm16;
   logic [SP_W-1:0]   StackAddr;
   logic              IllegalOp, StackFault;

   int n_chk = 0;
   int n_err = 0;

   // Hand-built control words {RegDst,RegWrite,MemRead,MemWrite,MemToReg,NeedZEXT,ALUsrc,ALUop,Branch,Jump,Link,StackOp}
   localparam logic [16:0] C_ADDI = 17'b0_1_0_0_0_0_1_0010_0_00_0_00;
   localparam logic [16:0] C_JAL  = 17'b0_1_0_0_0_0_0_0000_0_01_1_00;
   localparam logic [16:0] C_LW   = 17'b0_1_1_0_1_0_1_0010_0_00_0_00;
   localparam logic [16:0] C_ADD  = 17'b1_1_0_0_0_0_0_0000_0_00_0_00;
   localparam logic [16:0] C_PUSH = 17'b0_0_0_0_0_0_1_1100_0_00_0_10;
   localparam logic [16:0] C_POP  = 17'b1_1_1_0_1_0_0_0000_0_00_0_11;

   id_stage #(.ADDR_W(ADDR_W), .STACK_DEPTH(DEPTH), .LINK_REG(31)) dut (
      .clk        (clk),
      .rst        (rst),
      .InValid    (InValid),
      .InReady    (InReady),
      .Instr      (Instr),
      .InPC       (InPC),
      .Flush      (Flush),
      .OutValid   (OutValid),
      .OutReady   (OutReady),
      .Ctrl       (Ctrl),
      .Rs         (Rs),
      .Rt         (Rt),
      .Dst        (Dst),
      .Imm16      (Imm16),
      .OutPC      (OutPC),
      .StackAddr  (StackAddr),
      .IllegalOp  (IllegalOp),
      .StackFault (StackFault)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Sample point: 1 time unit after the rising edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
      return {6'b000000, rs, rt, rd, 5'd0, funct};
   endfunction

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; InValid = 1'b0; Instr = '0; InPC = '0; Flush = 1'b0; OutReady = 1'b0;
      #2;
      check("rst_outvalid", OutValid, 0);
      check("rst_inready", InReady, 0);
      check("rst_ctrl", Ctrl, 0);
      check("rst_stackfault", StackFault, 0);
      cyc(); cyc();
      rst = 1'b0;

      // addi r2,r1,5 then jal
      OutReady = 1'b1; InValid = 1'b1; Instr = enc_i(6'b001000, 5'd1, 5'd2, 16'd5); InPC = 32'h100;
      #1 check("addi_inready", InReady, 1);
      cyc();
      check("addi_valid", OutValid, 1);
      check("addi_ctrl", Ctrl, C_ADDI);
      check("addi_dst", Dst, 2);
      check("addi_imm", Imm16, 5);
      check("addi_rs", Rs, 1);
      check("addi_pc", OutPC, 32'h100);
      Instr = enc_i(6'b000011, 5'd0, 5'd0, 16'h0040); InPC = 32'h104;
      cyc();
      check("jal_ctrl", Ctrl, C_JAL);
      check("jal_dst", Dst, 31);
      InValid = 1'b0;
      cyc();
      check("drain_valid", OutValid, 0);

      // lw r3,0(r1) followed by dependent add r4,r3,r5
      InValid = 1'b1; Instr = enc_i(6'b100011, 5'd1, 5'd3, 16'd0); InPC = 32'h200;
      cyc();
      check("lw_ctrl", Ctrl, C_LW);
      check("lw_dst", Dst, 3);
      Instr = enc_r(5'd3, 5'd5, 5'd4, 6'b100000); InPC = 32'h204;
      #1 check("lu_stall_inready", InReady, 0);
      cyc();
      check("lu_bubble", OutValid, 0);
      check("lu_resume_inready", InReady, 1);
      cyc();
      check("lu_add_valid", OutValid, 1);
      check("lu_add_ctrl", Ctrl, C_ADD);
      check("lu_add_dst", Dst, 4);
      check("lu_add_pc", OutPC, 32'h204);

      // lw r6 then rt-dependence: sw reads rt (stall), addi does not
      Instr = enc_i(6'b100011, 5'd1, 5'd6, 16'd8);
      cyc();
      Instr = enc_i(6'b101011, 5'd1, 5'd6, 16'd0);
      #1 check("lu_sw_rt_stall", InReady, 0);
      Instr = enc_i(6'b001000, 5'd1, 5'd6, 16'd0);
      #1 check("lu_addi_rt_nostall", InReady, 1);

      // lw r0 then add using r0: no stall
      Instr = enc_i(6'b100011, 5'd1, 5'd0, 16'd0);
      cyc();
      Instr = enc_r(5'd0, 5'd5, 5'd4, 6'b100000);
      #1 check("lu_r0_inready", InReady, 1);
      cyc();
      check("lu_r0_no_bubble", OutValid, 1);
      check("lu_r0_ctrl", Ctrl, C_ADD);
      InValid = 1'b0;
      cyc();

      // Five pushes against a 4-entry stack
      check("stk_sp_start", dut.sp_q, 0);
      InValid = 1'b1; Instr = enc_i(6'b110000, 5'd2, 5'd3, 16'd0);
      for (int i = 0; i < 5; i++) begin
         cyc();
         if (i < 4) begin
            check($sformatf("push%0d_addr", i), StackAddr, i);
            check($sformatf("push%0d_fault", i), StackFault, 0);
         end else begin
            check("push4_fault", StackFault, 1);
            check("push4_addr", StackAddr, 0);
            check("push4_sp", dut.sp_q, 4);
         end
      end
      check("push_ctrl", Ctrl, C_PUSH);

      // Five pops back down
      Instr = {6'b110001, 5'd0, 5'd0, 5'd7, 11'd0};
      for (int i = 0; i < 5; i++) begin
         cyc();
         if (i < 4) check($sformatf("pop%0d_addr", i), StackAddr, 3 - i);
         else begin
            check("pop4_addr", StackAddr, 0);
            check("pop4_sp", dut.sp_q, 0);
            check("pop4_fault_sticky", StackFault, 1);
         end
      end
      check("pop_ctrl", Ctrl, C_POP);
      check("pop_dst", Dst, 7);
      InValid = 1'b0;
      cyc();

      // Push, then flush it (with a retried push presented alongside)
      InValid = 1'b1; Instr = enc_i(6'b110000, 5'd2, 5'd3, 16'd0); InPC = 32'h300;
      cyc();
      check("fl_push_addr", StackAddr, 0);
      check("fl_push_sp", dut.sp_q, 1);
      OutReady = 1'b0; Flush = 1'b1;
      #1 check("fl_inready", InReady, 0);
      cyc();
      check("fl_valid", OutValid, 0);
      check("fl_sp_restored", dut.sp_q, 0);
      Flush = 1'b0; OutReady = 1'b1;
      cyc();
      check("fl_retry_valid", OutValid, 1);
      check("fl_retry_addr", StackAddr, 0);
      check("fl_retry_sp", dut.sp_q, 1);

      // Illegal opcode, then output stall for three cycles
      Instr = enc_i(6'b111111, 5'd4, 5'd9, 16'h1234); InPC = 32'h400;
      cyc();
      check("ill_valid", OutValid, 1);
      check("ill_flag", IllegalOp, 1);
      check("ill_ctrl", Ctrl, 0);
      OutReady = 1'b0; Instr = enc_i(6'b001000, 5'd1, 5'd2, 16'd7); InPC = 32'h404;
      for (int i = 0; i < 3; i++) begin
         #1 check($sformatf("hold%0d_inready", i), InReady, 0);
         cyc();
         check($sformatf("hold%0d_valid", i), OutValid, 1);
         check($sformatf("hold%0d_ill", i), IllegalOp, 1);
         check($sformatf("hold%0d_ctrl", i), Ctrl, 0);
         check($sformatf("hold%0d_pc", i), OutPC, 32'h400);
         check($sformatf("hold%0d_imm", i), Imm16, 16'h1234);
         check($sformatf("hold%0d_dst", i), Dst, 9);
      end

      // Asynchronous reset with a valid entry and a sticky fault pending
      rst = 1'b1;
      #1;
      check("arst_valid", OutValid, 0);
      check("arst_fault", StackFault, 0);
      check("arst_sp", dut.sp_q, 0);
      check("arst_inready", InReady, 0);
      check("arst_ill", IllegalOp, 0);
      check("arst_pc", OutPC, 0);
      InValid = 1'b0;
      cyc();
      rst = 1'b0;
      cyc();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Registered instruction-decode stage for the MIPS-style core; successor to the combinational control decoder.
- Decodes Opcode/Funct into a packed control bundle and holds it in an ID/EX pipeline register with a valid/ready handshake.
- Adds load-use hazard stalling, flush, illegal-opcode detection and a parametrised hardware stack pointer for push/pop.
- Sits between the fetch stage (upstream) and the execute stage (downstream).

Parameters:
- ADDR_W, 32, width of PC and of the OutPC field.
- STACK_DEPTH, 16, number of stack entries; push/pop bound.
- SP_W, clog2(STACK_DEPTH+1), stack pointer width (localparam, derived).
- LINK_REG, 31, destination register written by jal.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- InValid  in  1  fetch presents an instruction.
- InReady  out  1  stage accepts the instruction this cycle.
- Instr  in  32  instruction word: [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [15:0] imm16, [5:0] funct.
- InPC  in  ADDR_W  PC of Instr.
- Flush  in  1  discard the output register contents (branch/jump redirect).
- OutValid  out  1  output register holds a decoded instruction.
- OutReady  in  1  execute consumes the output register.
- Ctrl  out  CTRL_W(17)  packed {RegDst, RegWrite, MemRead, MemWrite, MemToReg, NeedZEXT, ALUsrc, ALUop[3:0], Branch, Jump[1:0], Link, StackOp[1:0]}.
- Rs, Rt, Dst  out  5 each  source registers and resolved destination register.
- Imm16  out  16  raw immediate.
- OutPC  out  ADDR_W  PC of the decoded instruction.
- StackAddr  out  SP_W  stack slot for push (SP) or pop (SP-1); 0 otherwise.
- IllegalOp  out  1  output instruction has an unknown opcode.
- StackFault  out  1  sticky overflow/underflow flag.

Behaviour:
- Reset (async, any cycle): OutValid=0, Ctrl=0, Rs/Rt/Dst/Imm16/OutPC/StackAddr=0, IllegalOp=0, StackFault=0, SP=0, InReady=0 while rst is high.
- Decode table:
  - 000000 R-type: RegDst, RegWrite, ALUop=Funct[3:0].
  - 001000 addi: RegWrite, ALUsrc, ALUop=0010.
  - 001100 andi: RegWrite, NeedZEXT, ALUsrc, ALUop=0000.
  - 001101 ori: RegWrite, NeedZEXT, ALUsrc, ALUop=0001.
  - 000100 beq: Branch, ALUop=0011.
  - 000010 j: Jump=01.
  - 000011 jal: Jump=01, Link, RegWrite, Dst=LINK_REG.
  - 000101 jr: Jump=10.
  - 100011 lw: RegWrite, MemRead, MemToReg, ALUsrc, ALUop=0010.
  - 101011 sw: MemWrite, ALUsrc, ALUop=0010.
  - 110000 push: ALUsrc, ALUop=1100, StackOp=10.
  - 110001 pop: RegDst, RegWrite, MemToReg, MemRead, StackOp=11.
  - Unlisted bits are 0.
- Dst: rd if RegDst, LINK_REG if Link, else rt.
- Unknown opcode: Ctrl=0, IllegalOp=1, OutValid still asserted so the exception is precise.
- Rt is a read source only for R-type, beq, sw and push.
- Hazard = OutValid & Ctrl.MemRead & Dst!=0 & InValid & (Instr.rs==Dst | (rt-read & Instr.rt==Dst)).
- InReady = ~rst & ~Flush & ~Hazard & (~OutValid | OutReady).
- Accept (InValid & InReady): decoded fields load into the output register next edge, OutValid=1. Latency is 1 cycle.
- OutValid & OutReady & no accept: OutValid=0 next edge. When a load leaves under Hazard, this yields exactly one bubble.
- ~OutReady with OutValid: all outputs hold stable.
- Flush: OutValid=0 next edge; Flush has priority over accept and hazard. If the flushed entry was a non-faulted push, SP decrements; if a non-faulted pop, SP increments.
- Stack, evaluated at accept:
  - Push with SP<STACK_DEPTH: StackAddr=SP, SP++.
  - Push with SP==STACK_DEPTH: SP unchanged, StackFault=1, entry marked faulted.
  - Pop with SP>0: StackAddr=SP-1, SP--.
  - Pop with SP==0: SP unchanged, StackFault=1, entry marked faulted.
- StackFault clears only on reset.
- Simultaneous Flush and accept: accept is suppressed by InReady=0; fetch retries next cycle.

Decomposition:
- id_pkg holds: opcode constants, ALUop constants, Ctrl field offsets and CTRL_W, STACKOP_NONE/PUSH/POP encodings.
- id_decode is a combinational sub-module (Instr -> Ctrl, Dst, rt-read, illegal).
- id_stage owns the pipeline register, hazard logic and SP.

Test Plan:
- Reset mid-stream with OutValid=1 -> next sample has OutValid=0, SP=0, StackFault=0, with no clock edge required.
- addi r2,r1,5 then OutReady=1 -> 1 cycle later Ctrl has RegWrite=1, ALUsrc=1, ALUop=0010; Dst=2, Imm16=5.
- lw r3 then add r4,r3,r5 with OutReady=1 -> InReady=0 for one cycle, one bubble (OutValid=0), add follows. Repeat with dest r0 -> no stall.
- STACK_DEPTH=4: 5 pushes -> StackAddr 0,1,2,3; 5th sets StackFault=1 with SP=4. 5 pops -> StackAddr 3,2,1,0; 5th faults with SP=0.
- push accepted, then Flush while it sits in the output register -> OutValid=0, SP returns to its prior value; next push gets the same StackAddr.
- Opcode 111111 -> IllegalOp=1, Ctrl=0. OutReady=0 for 3 cycles -> all outputs held, InReady=0.
